// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory-port arbiter, its three requesters
// (fetch, load, ROB store commit) and the single dataMemory port.
interface mem_port_arbiter_if;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchGrant;
  logic        fetchDone;
  logic        loadReq;
  logic [31:0] loadAddr;
  logic        loadGrant;
  logic        loadDone;
  logic        storeReq;
  logic [31:0] storeAddr;
  logic [31:0] storeData;
  logic [1:0]  storeType;
  logic        storeGrant;
  logic        storeDone;
  logic        memReadEn;
  logic        memWriteEn;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [1:0]  memWriteType;
  logic [31:0] memReadData;
  logic [31:0] readData;
  logic        busy;

  // Arbiter side
  modport slave (
    input  fetchReq, fetchAddr, loadReq, loadAddr,
           storeReq, storeAddr, storeData, storeType, memReadData,
    output fetchGrant, fetchDone, loadGrant, loadDone, storeGrant, storeDone,
           memReadEn, memWriteEn, memAddr, memWriteData, memWriteType,
           readData, busy
  );

  // Requester / memory side
  modport master (
    output fetchReq, fetchAddr, loadReq, loadAddr,
           storeReq, storeAddr, storeData, storeType, memReadData,
    input  fetchGrant, fetchDone, loadGrant, loadDone, storeGrant, storeDone,
           memReadEn, memWriteEn, memAddr, memWriteData, memWriteType,
           readData, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: one dataMemory access in flight at a time, shared by
// store commit, load and fetch. Fixed priority store > load > fetch, with
// load/fetch promoted above store once they have waited STARVE_LIMIT cycles.
// Sequence per access: IDLE -> ACCESS (LATENCY cycles) -> RESP -> IDLE.
module mem_port_arbiter #(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [LW-1:0] LAT_LAST   = LW'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_LOAD, SRC_STORE} src_t;

  state_t        state_r;
  src_t          owner_r;
  logic [LW-1:0] lat_cnt_r;
  logic [SW-1:0] load_starve_r;
  logic [SW-1:0] fetch_starve_r;

  logic        fetch_grant_r;
  logic        fetch_done_r;
  logic        load_grant_r;
  logic        load_done_r;
  logic        store_grant_r;
  logic        store_done_r;
  logic        mem_read_en_r;
  logic        mem_write_en_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [1:0]  mem_wtype_r;
  logic [31:0] read_data_r;
  logic        busy_r;

  src_t winner_s;
  logic load_starved_s;
  logic fetch_starved_s;
  logic load_served_s;
  logic fetch_served_s;

  // Next value of a starve counter: cleared while idle-requesting stops or the
  // unit owns the port, otherwise counts waiting cycles up to the limit.
  function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] cnt,
                                                input logic          req,
                                                input logic          served);
    if (!req || served) begin
      starve_next = {SW{1'b0}};
    end else if (cnt < STARVE_MAX) begin
      starve_next = cnt + SW'(1);
    end else begin
      starve_next = cnt;
    end
  endfunction

  // Starvation flags and "unit is being served" (granted now or owns the port)
  always_comb begin
    load_starved_s  = bus.loadReq && (load_starve_r == STARVE_MAX);
    fetch_starved_s = bus.fetchReq && (fetch_starve_r == STARVE_MAX);
    load_served_s   = ((state_r == ST_IDLE) && (winner_s == SRC_LOAD)) ||
                      ((state_r != ST_IDLE) && (owner_r == SRC_LOAD));
    fetch_served_s  = ((state_r == ST_IDLE) && (winner_s == SRC_FETCH)) ||
                      ((state_r != ST_IDLE) && (owner_r == SRC_FETCH));
  end

  // Priority pick: starved load > starved fetch > store > load > fetch
  always_comb begin
    winner_s = SRC_NONE;
    if (load_starved_s) begin
      winner_s = SRC_LOAD;
    end else if (fetch_starved_s) begin
      winner_s = SRC_FETCH;
    end else if (bus.storeReq) begin
      winner_s = SRC_STORE;
    end else if (bus.loadReq) begin
      winner_s = SRC_LOAD;
    end else if (bus.fetchReq) begin
      winner_s = SRC_FETCH;
    end else begin
      winner_s = SRC_NONE;
    end
  end

  // Starve counters for load and fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      load_starve_r  <= {SW{1'b0}};
      fetch_starve_r <= {SW{1'b0}};
    end else begin
      load_starve_r  <= starve_next(load_starve_r, bus.loadReq, load_served_s);
      fetch_starve_r <= starve_next(fetch_starve_r, bus.fetchReq, fetch_served_s);
    end
  end

  // Access FSM with all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      owner_r        <= SRC_NONE;
      lat_cnt_r      <= {LW{1'b0}};
      fetch_grant_r  <= 1'b0;
      fetch_done_r   <= 1'b0;
      load_grant_r   <= 1'b0;
      load_done_r    <= 1'b0;
      store_grant_r  <= 1'b0;
      store_done_r   <= 1'b0;
      mem_read_en_r  <= 1'b0;
      mem_write_en_r <= 1'b0;
      mem_addr_r     <= 32'h0000_0000;
      mem_wdata_r    <= 32'h0000_0000;
      mem_wtype_r    <= 2'b00;
      read_data_r    <= 32'h0000_0000;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          fetch_done_r <= 1'b0;
          load_done_r  <= 1'b0;
          store_done_r <= 1'b0;
          lat_cnt_r    <= {LW{1'b0}};
          if (winner_s != SRC_NONE) begin
            state_r        <= ST_ACCESS;
            owner_r        <= winner_s;
            busy_r         <= 1'b1;
            fetch_grant_r  <= (winner_s == SRC_FETCH);
            load_grant_r   <= (winner_s == SRC_LOAD);
            store_grant_r  <= (winner_s == SRC_STORE);
            mem_read_en_r  <= (winner_s != SRC_STORE);
            mem_write_en_r <= (winner_s == SRC_STORE);
            case (winner_s)
              SRC_STORE: begin
                mem_addr_r  <= bus.storeAddr;
                mem_wdata_r <= bus.storeData;
                mem_wtype_r <= bus.storeType;
              end
              SRC_LOAD: begin
                mem_addr_r  <= bus.loadAddr;
                mem_wdata_r <= 32'h0000_0000;
                mem_wtype_r <= 2'b00;
              end
              SRC_FETCH: begin
                mem_addr_r  <= bus.fetchAddr;
                mem_wdata_r <= 32'h0000_0000;
                mem_wtype_r <= 2'b00;
              end
              default: begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_wtype_r <= mem_wtype_r;
              end
            endcase
          end else begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            fetch_grant_r  <= 1'b0;
            load_grant_r   <= 1'b0;
            store_grant_r  <= 1'b0;
            mem_read_en_r  <= 1'b0;
            mem_write_en_r <= 1'b0;
          end
        end

        ST_ACCESS: begin
          fetch_grant_r <= 1'b0;
          load_grant_r  <= 1'b0;
          store_grant_r <= 1'b0;
          if (lat_cnt_r == LAT_LAST) begin
            state_r        <= ST_RESP;
            mem_read_en_r  <= 1'b0;
            mem_write_en_r <= 1'b0;
            fetch_done_r   <= (owner_r == SRC_FETCH);
            load_done_r    <= (owner_r == SRC_LOAD);
            store_done_r   <= (owner_r == SRC_STORE);
            if (owner_r != SRC_STORE) begin
              read_data_r <= bus.memReadData;
            end else begin
              read_data_r <= read_data_r;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r + LW'(1);
          end
        end

        ST_RESP: begin
          state_r      <= ST_IDLE;
          owner_r      <= SRC_NONE;
          busy_r       <= 1'b0;
          fetch_done_r <= 1'b0;
          load_done_r  <= 1'b0;
          store_done_r <= 1'b0;
        end

        default: begin
          state_r        <= ST_IDLE;
          owner_r        <= SRC_NONE;
          busy_r         <= 1'b0;
          fetch_grant_r  <= 1'b0;
          load_grant_r   <= 1'b0;
          store_grant_r  <= 1'b0;
          fetch_done_r   <= 1'b0;
          load_done_r    <= 1'b0;
          store_done_r   <= 1'b0;
          mem_read_en_r  <= 1'b0;
          mem_write_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetchGrant   = fetch_grant_r;
  assign bus.fetchDone    = fetch_done_r;
  assign bus.loadGrant    = load_grant_r;
  assign bus.loadDone     = load_done_r;
  assign bus.storeGrant   = store_grant_r;
  assign bus.storeDone    = store_done_r;
  assign bus.memReadEn    = mem_read_en_r;
  assign bus.memWriteEn   = mem_write_en_r;
  assign bus.memAddr      = mem_addr_r;
  assign bus.memWriteData = mem_wdata_r;
  assign bus.memWriteType = mem_wtype_r;
  assign bus.readData     = read_data_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LATENCY=2, STARVE_LIMIT=4).
// Memory model returns data only in the second read-enable cycle.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic mon_on = 1'b0;
  logic [1:0] en_cnt_r = 2'd0;

  int n_checks = 0;
  int n_fails  = 0;
  int grant_log [32];
  int done_log  [32];
  logic [31:0] rd_log [32];
  int wr_cycles;
  int rd_cycles;

  mem_port_arbiter_if bus_if();

  mem_port_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory model: read data valid only in the last read-enable cycle
  always_ff @(posedge clock) en_cnt_r <= bus_if.memReadEn ? en_cnt_r + 2'd1 : 2'd0;
  always_comb bus_if.memReadData = (bus_if.memReadEn && en_cnt_r == 2'd1) ?
                                   mdata(bus_if.memAddr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Invariants sampled on the falling edge
  always @(negedge clock) begin
    if (mon_on) begin
      chk("inv_grant_onehot", 32'($onehot0({bus_if.fetchGrant, bus_if.loadGrant, bus_if.storeGrant})), 32'd1);
      chk("inv_done_onehot", 32'($onehot0({bus_if.fetchDone, bus_if.loadDone, bus_if.storeDone})), 32'd1);
      chk("inv_en_excl", 32'(bus_if.memReadEn & bus_if.memWriteEn), 32'd0);
    end
  end

  // Run ncyc cycles, logging grants/dones per cycle (1=fetch 2=load 3=store);
  // a request is dropped on its done unless kept.
  task automatic run(input int ncyc, input logic keep_store, input logic keep_load);
    wr_cycles = 0;
    rd_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      grant_log[i] = 0;
      done_log[i]  = 0;
      rd_log[i]    = 32'h0;
    end
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (bus_if.fetchGrant) grant_log[i] = 1;
      else if (bus_if.loadGrant) grant_log[i] = 2;
      else if (bus_if.storeGrant) grant_log[i] = 3;
      if (bus_if.fetchDone) done_log[i] = 1;
      else if (bus_if.loadDone) done_log[i] = 2;
      else if (bus_if.storeDone) done_log[i] = 3;
      rd_log[i] = bus_if.readData;
      if (bus_if.memWriteEn) begin
        wr_cycles++;
        chk("wr_addr", bus_if.memAddr, bus_if.storeAddr);
        chk("wr_data", bus_if.memWriteData, bus_if.storeData);
        chk("wr_type", 32'(bus_if.memWriteType), 32'(bus_if.storeType));
      end
      if (bus_if.memReadEn) rd_cycles++;
      if (bus_if.fetchDone) bus_if.fetchReq = 1'b0;
      if (bus_if.loadDone && !keep_load) bus_if.loadReq = 1'b0;
      if (bus_if.storeDone && !keep_store) bus_if.storeReq = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus_if.busy && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_if.fetchReq  = 1'b0;
    bus_if.fetchAddr = 32'h0;
    bus_if.loadReq   = 1'b0;
    bus_if.loadAddr  = 32'h0;
    bus_if.storeReq  = 1'b0;
    bus_if.storeAddr = 32'h0;
    bus_if.storeData = 32'h0;
    bus_if.storeType = 2'b00;
    tick();
    tick();
    mon_on = 1'b1;

    // Reset state
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_rden", 32'(bus_if.memReadEn), 32'd0);
    chk("rst_wren", 32'(bus_if.memWriteEn), 32'd0);
    chk("rst_rdata", bus_if.readData, 32'h0);
    chk("rst_addr", bus_if.memAddr, 32'h0);
    chk("rst_grants", 32'({bus_if.fetchGrant, bus_if.loadGrant, bus_if.storeGrant}), 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch
    bus_if.fetchAddr = 32'h0000_0010;
    bus_if.fetchReq  = 1'b1;
    tick();
    chk("f_grant", 32'(bus_if.fetchGrant), 32'd1);
    chk("f_rden1", 32'(bus_if.memReadEn), 32'd1);
    chk("f_addr", bus_if.memAddr, 32'h0000_0010);
    chk("f_busy", 32'(bus_if.busy), 32'd1);
    tick();
    chk("f_grant_pulse", 32'(bus_if.fetchGrant), 32'd0);
    chk("f_rden2", 32'(bus_if.memReadEn), 32'd1);
    tick();
    chk("f_done", 32'(bus_if.fetchDone), 32'd1);
    chk("f_rdata", bus_if.readData, 32'hDEAD_BEEF);
    chk("f_rden_off", 32'(bus_if.memReadEn), 32'd0);
    chk("f_busy_resp", 32'(bus_if.busy), 32'd1);
    bus_if.fetchReq = 1'b0;
    tick();
    chk("f_done_pulse", 32'(bus_if.fetchDone), 32'd0);
    tick();
    chk("f_no_regrant", 32'(bus_if.fetchGrant), 32'd0);
    chk("f_idle", 32'(bus_if.busy), 32'd0);

    // All three together: store, load, fetch, 4 cycles apart
    bus_if.storeAddr = 32'h0000_0100;
    bus_if.storeData = 32'h1234_5678;
    bus_if.storeType = 2'b10;
    bus_if.loadAddr  = 32'h0000_0200;
    bus_if.fetchAddr = 32'h0000_0300;
    bus_if.storeReq  = 1'b1;
    bus_if.loadReq   = 1'b1;
    bus_if.fetchReq  = 1'b1;
    run(12, 1'b0, 1'b0);
    chk("all_g1_store", grant_log[1], 32'd3);
    chk("all_g5_load", grant_log[5], 32'd2);
    chk("all_g9_fetch", grant_log[9], 32'd1);
    chk("all_d3_store", done_log[3], 32'd3);
    chk("all_d7_load", done_log[7], 32'd2);
    chk("all_d11_fetch", done_log[11], 32'd1);
    chk("all_store_keeps_rdata", rd_log[3], 32'hDEAD_BEEF);
    chk("all_load_rdata", rd_log[7], mdata(32'h0000_0200));
    chk("all_fetch_rdata", rd_log[11], mdata(32'h0000_0300));
    chk("all_wr_cycles", wr_cycles, 32'd2);
    chk("all_rd_cycles", rd_cycles, 32'd4);

    // Starvation: store held permanently, load held too
    bus_if.storeAddr = 32'h0000_0180;
    bus_if.storeData = 32'hCAFE_0001;
    bus_if.storeType = 2'b01;
    bus_if.loadAddr  = 32'h0000_0280;
    bus_if.storeReq  = 1'b1;
    bus_if.loadReq   = 1'b1;
    run(14, 1'b1, 1'b1);
    chk("stv_g1_store", grant_log[1], 32'd3);
    chk("stv_g5_load", grant_log[5], 32'd2);
    chk("stv_d7_load", done_log[7], 32'd2);
    chk("stv_load_rdata", rd_log[7], mdata(32'h0000_0280));
    chk("stv_g9_store", grant_log[9], 32'd3);
    chk("stv_g13_load", grant_log[13], 32'd2);
    bus_if.storeReq = 1'b0;
    bus_if.loadReq  = 1'b0;
    wait_idle("stv_idle_timeout");
    tick();

    // Request dropped after grant
    bus_if.loadAddr = 32'h0000_0240;
    bus_if.loadReq  = 1'b1;
    tick();
    chk("drop_grant", 32'(bus_if.loadGrant), 32'd1);
    bus_if.loadReq = 1'b0;
    tick();
    tick();
    chk("drop_done", 32'(bus_if.loadDone), 32'd1);
    chk("drop_rdata", bus_if.readData, mdata(32'h0000_0240));
    tick();
    tick();
    chk("drop_no_regrant", 32'(bus_if.loadGrant), 32'd0);
    chk("drop_idle", 32'(bus_if.busy), 32'd0);

    // Reset during the first ACCESS cycle
    bus_if.storeAddr = 32'h0000_01C0;
    bus_if.storeData = 32'h55AA_33CC;
    bus_if.storeType = 2'b11;
    bus_if.loadAddr  = 32'h0000_02C0;
    bus_if.storeReq  = 1'b1;
    bus_if.loadReq   = 1'b1;
    tick();
    chk("rma_grant", 32'(bus_if.storeGrant), 32'd1);
    chk("rma_wren", 32'(bus_if.memWriteEn), 32'd1);
    reset = 1'b1;
    tick();
    chk("rma_wren_off", 32'(bus_if.memWriteEn), 32'd0);
    chk("rma_rden_off", 32'(bus_if.memReadEn), 32'd0);
    chk("rma_busy", 32'(bus_if.busy), 32'd0);
    chk("rma_no_done", 32'(bus_if.storeDone), 32'd0);
    chk("rma_rdata", bus_if.readData, 32'h0);
    chk("rma_load_starve", 32'(dut.load_starve_r), 32'd0);
    reset = 1'b0;
    run(8, 1'b0, 1'b0);
    chk("rma_g1_store", grant_log[1], 32'd3);
    chk("rma_no_early_done", done_log[1] + done_log[2], 32'd0);
    chk("rma_d3_store", done_log[3], 32'd3);
    chk("rma_store_rdata", rd_log[3], 32'h0);
    chk("rma_g5_load", grant_log[5], 32'd2);
    chk("rma_d7_load", done_log[7], 32'd2);
    chk("rma_load_rdata", rd_log[7], mdata(32'h0000_02C0));
    tick();

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
